icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 133 +++++++++++++
 tb/tb_icache.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache. Each frame holds one word.
// A hit is returned in the same cycle. A miss fetches the word from memory, and
// the word is forwarded to the datapath in the cycle the fill completes.
// Optional build macro ICACHE_STATS_EN adds the hit_count and miss_count outputs.
module icache #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        inval,
    output logic        ramREN,
    output logic [31:0] ramaddr,
    input  logic [31:0] ramload,
    input  logic        iwait
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IDXW = $clog2(SETS);
    localparam int TAGW = 30 - IDXW;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [SETS-1:0]     r_valid;
    logic [TAGW-1:0]     r_tag  [SETS];
    logic [31:0]         r_data [SETS];
    logic [31:0]         r_faddr;

    logic [IDXW-1:0]     w_idx;
    logic [TAGW-1:0]     w_tag;
    logic [IDXW-1:0]     w_fidx;
    logic [TAGW-1:0]     w_ftag;
    logic                w_lookup_hit;
    logic                w_fill;
    logic                w_fwd_hit;
    logic                w_miss;

    assign w_idx  = imemaddr[IDXW+1:2];
    assign w_tag  = imemaddr[31:IDXW+2];
    assign w_fidx = r_faddr[IDXW+1:2];
    assign w_ftag = r_faddr[31:IDXW+2];

    // Frame lookup and fill/forward qualifiers derived from the current state
    always_comb begin
        w_lookup_hit = 1'b0;
        w_fill       = 1'b0;
        w_fwd_hit    = 1'b0;
        w_miss       = 1'b0;
        if (r_state == IDLE) begin
            w_lookup_hit = imemREN && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
            w_miss       = imemREN && !w_lookup_hit;
        end else begin
            w_fill    = !iwait;
            w_fwd_hit = !iwait && imemREN && (imemaddr[31:2] == r_faddr[31:2]);
        end
    end

    // Next state and datapath/memory-side outputs
    always_comb begin
        w_next_state = r_state;
        ihit         = 1'b0;
        imemload     = 32'h0;
        ramREN       = 1'b0;
        ramaddr      = 32'h0;
        case (r_state)
            IDLE: begin
                if (w_lookup_hit) begin
                    ihit     = 1'b1;
                    imemload = r_data[w_idx];
                end
                if (w_miss) w_next_state = FETCH;
            end
            FETCH: begin
                ramREN  = 1'b1;
                ramaddr = r_faddr & 32'hFFFF_FFFC;
                if (w_fwd_hit) begin
                    ihit     = 1'b1;
                    imemload = ramload;
                end
                if (w_fill) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register, fetch address latch and valid bits (reset abandons a fill)
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_faddr <= 32'h0;
            r_valid <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_miss) r_faddr <= imemaddr;
            if (inval) r_valid <= '0;
            else if (w_fill) r_valid[w_fidx] <= 1'b1;
        end
    end

    // Tag and data arrays; refill overwrites unconditionally
    always_ff @(posedge CLK) begin
        if (w_fill) begin
            r_tag[w_fidx]  <= w_ftag;
            r_data[w_fidx] <= ramload;
        end
    end

`ifdef ICACHE_STATS_EN
    // Hit and miss counters, wrapping, untouched by invalidate
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= 32'h0;
            miss_count <= 32'h0;
        end else begin
            if (ihit) hit_count <= hit_count + 32'd1;
            if (w_miss) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache: randomized and directed stimulus for icache, checked by a scoreboard
// against a frame-occupancy reference model (each frame records the word address
// it holds). Stats outputs are checked when ICACHE_STATS_EN is defined.
`timescale 1ns/1ps
module tb_icache;

    localparam int SETS = 16;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = 32'h0;
    logic        ihit;
    logic [31:0] imemload;
    logic        inval = 1'b0;
    logic        ramREN;
    logic [31:0] ramaddr;
    logic [31:0] ramload = 32'h0;
    logic        iwait = 1'b1;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache #(.SETS(SETS)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .inval(inval), .ramREN(ramREN),
        .ramaddr(ramaddr), .ramload(ramload), .iwait(iwait)
`ifdef ICACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        hit;
        logic [31:0] load;
        logic        ren;
        logic [31:0] raddr;
        logic [31:0] hits;
        logic [31:0] misses;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   running = 1'b0;
    int   cyc = 0;

    // Reference model: which word address each frame holds, whether it is valid,
    // and the word address of an outstanding fetch.
    bit          m_ok   [SETS];
    logic [29:0] m_word [SETS];
    logic [31:0] m_dat  [SETS];
    bit          m_fetching;
    logic [29:0] m_fword;
    logic [31:0] m_hits, m_misses;

    function automatic logic [31:0] memval(input logic [29:0] w);
        if (w == 30'h10) return 32'h8C22_0004;
        return ({w, 2'b00} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SETS; i++) m_ok[i] = 1'b0;
        m_fetching = 1'b0;
        m_fword = '0;
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req, input int c);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=0x%08h required=0x%08h", name, c, act, req);
        end
    endtask

    // One clock cycle: drive inputs after the edge, predict outputs, advance model.
    task automatic cycle(input bit rst_n, input bit ren, input logic [31:0] addr,
                         input bit inv, input bit wt);
        exp_t e;
        int   idx;
        logic [29:0] wa;
        @(posedge CLK);
        #1;
        cyc++;
        nRST = rst_n;
        imemREN = ren;
        imemaddr = addr;
        inval = inv;
        iwait = wt;
        ramload = (m_fetching && !wt) ? memval(m_fword) : $urandom;
        if (!rst_n) model_reset();
        wa  = addr[31:2];
        idx = int'(wa % SETS);
        e.hit = 1'b0; e.load = 32'h0; e.ren = 1'b0; e.raddr = 32'h0;
        e.hits = m_hits; e.misses = m_misses; e.cyc = cyc;
        if (rst_n) begin
            if (!m_fetching) begin
                e.hit = ren && m_ok[idx] && (m_word[idx] == wa);
                if (e.hit) e.load = m_dat[idx];
                if (inv) for (int i = 0; i < SETS; i++) m_ok[i] = 1'b0;
                if (ren && !e.hit) begin
                    m_fetching = 1'b1;
                    m_fword = wa;
                    m_misses++;
                end
            end else begin
                e.ren = 1'b1;
                e.raddr = {m_fword, 2'b00};
                if (inv) for (int i = 0; i < SETS; i++) m_ok[i] = 1'b0;
                if (!wt) begin
                    e.hit = ren && (wa == m_fword);
                    if (e.hit) e.load = ramload;
                    m_word[int'(m_fword % SETS)] = m_fword;
                    m_dat[int'(m_fword % SETS)]  = ramload;
                    m_ok[int'(m_fword % SETS)]   = !inv;
                    m_fetching = 1'b0;
                end
            end
            if (e.hit) m_hits++;
        end
        exp_q.push_back(e);
    endtask

    task automatic fetch(input logic [31:0] a, input int waits);
        cycle(1, 1, a, 0, 1);
        for (int i = 0; i < waits; i++) cycle(1, 1, a, 0, 1);
        cycle(1, 1, a, 0, 0);
    endtask

    // Monitor: every cycle the DUT presents outputs; compare against the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (running) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty cycle=%0d actual=0 required=1", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("ihit", {31'h0, ihit}, {31'h0, e.hit}, e.cyc);
                    chk("imemload", imemload, e.load, e.cyc);
                    chk("ramREN", {31'h0, ramREN}, {31'h0, e.ren}, e.cyc);
                    chk("ramaddr", ramaddr, e.raddr, e.cyc);
`ifdef ICACHE_STATS_EN
                    chk("hit_count", hit_count, e.hits, e.cyc);
                    chk("miss_count", miss_count, e.misses, e.cyc);
`endif
                end
            end
        end
    end

    initial begin
        model_reset();
        running = 1'b1;
        // Reset state, then cold miss on 0x40 with three wait cycles
        cycle(0, 1, 32'h40, 0, 1);
        cycle(0, 1, 32'h40, 0, 1);
        fetch(32'h40, 3);
        // Hit on 0x40
        cycle(1, 1, 32'h40, 0, 1);
        cycle(1, 0, 32'h40, 0, 1);
        // Conflict: 0x80 shares index 0 with 0x40
        fetch(32'h80, 1);
        cycle(1, 1, 32'h80, 0, 1);
        fetch(32'h40, 0);
        // Squash: miss on 0x44, branch to 0x100 during wait
        cycle(1, 1, 32'h44, 0, 1);
        cycle(1, 1, 32'h100, 0, 1);
        cycle(1, 1, 32'h100, 0, 0);
        fetch(32'h100, 1);
        cycle(1, 1, 32'h44, 0, 1);
        // Invalidate: fill 0x00, 0x04, pulse inval, both miss again
        fetch(32'h00, 0);
        fetch(32'h04, 0);
        cycle(1, 1, 32'h00, 1, 1);
        fetch(32'h00, 0);
        fetch(32'h04, 0);
        // Inval coincident with fill of 0x08, then a stale re-request misses
        cycle(1, 1, 32'h08, 0, 1);
        cycle(1, 1, 32'h08, 0, 1);
        cycle(1, 1, 32'h08, 1, 0);
        fetch(32'h08, 0);
        // Inval during wait: the later fill stays valid
        cycle(1, 1, 32'h0C, 0, 1);
        cycle(1, 1, 32'h0C, 1, 1);
        cycle(1, 1, 32'h0C, 0, 0);
        cycle(1, 1, 32'h0C, 0, 1);
        // Reset mid-fetch, then the same address misses
        cycle(1, 1, 32'hC0, 0, 1);
        cycle(1, 1, 32'hC0, 0, 1);
        cycle(0, 1, 32'hC0, 0, 1);
        fetch(32'hC0, 1);
        // Randomized traffic over a small address pool with tag aliasing
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] a;
            a = {($urandom_range(0, 3) == 0) ? 20'h00010 : 20'h0, 4'h0,
                 6'($urandom_range(0, 47)), 2'($urandom)};
            cycle(($urandom_range(0, 299) != 0), ($urandom_range(0, 4) != 0), a,
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) == 0));
        end
        @(negedge CLK);
        #1;
        running = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound
    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
